seg7_scan_reader: RTL and testbench

- Reader side of the common-anode multiplexed seven-segment display interface: samples the active-low segment bus and active-low digit-select lines, then reconstructs the hex value shown on each digit.
- Used as an on-chip monitor and self-check for the frequency-meter display path.
- Each digit's segment pattern must be stable before it is decoded.
- Illegal patterns are flagged.

---
 rtl/seg7_scan_reader.sv | 158 +++++++++++++++
 tb/tb_seg7_scan_reader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_reader.sv
// Monitor for a common-anode multiplexed 7-segment display: recovers the hex digit shown
// on each position once its pattern has been stable, and flags any pattern it cannot decode.
module seg7_scan_reader #(
  parameter int NDIG   = 4,
  parameter int STABLE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           seg_n,
  input  logic [NDIG-1:0]      an_n,
  input  logic                 err_clr,
  output logic [4*NDIG-1:0]    value,
  output logic [NDIG-1:0]      blank,
  output logic                 upd,
  output logic                 err
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [6:0]     s_seg;
  logic [NDIG-1:0] s_an;
  logic [3:0]     nlow;
  logic [IW-1:0]  idx;
  logic           qual, match, commit;
  logic           dec_hex, dec_blank;
  logic [3:0]     dec_nib, cur_nib;
  logic           chg, chg_q;

  always_comb begin
    nlow = '0;
    idx  = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an_n[i]) begin
        nlow = nlow + 4'd1;
        idx  = IW'(i);
      end
    end
    qual = (nlow == 4'd1);
  end

  // Each sample is counted as it is captured into s_seg/s_an, and the previous
  // capture doubles as the run's stored pattern, so the STABLE-th identical
  // capture commits on the very edge that registers it.
  assign match = (an_n == s_an) && (seg_n == s_seg);

  always_comb begin
    dec_hex   = 1'b1;
    dec_blank = 1'b0;
    dec_nib   = 4'h0;
    case (seg_n)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: begin
        dec_hex   = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_hex = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    commit  = 1'b0;
    if (!qual) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = COUNT;
          cnt_n   = CW'(1);
        end
        COUNT: begin
          if (match) begin
            if (cnt == CW'(STABLE - 1)) begin
              cnt_n   = CW'(STABLE);
              state_n = HELD;
              commit  = 1'b1;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end else begin
            cnt_n = CW'(1);
          end
        end
        HELD: begin
          if (!match) begin
            state_n = COUNT;
            cnt_n   = CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    cur_nib = value[4*int'(idx) +: 4];
    chg     = commit && ((dec_hex && ((cur_nib != dec_nib) || blank[idx])) ||
                         (dec_blank && !blank[idx]));
  end

  // chg_q delays the change flag so upd appears the cycle after the commit is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg <= 7'h7F;
      s_an  <= '1;
      state <= IDLE;
      cnt   <= '0;
      value <= '0;
      blank <= '1;
      err   <= 1'b0;
      chg_q <= 1'b0;
      upd   <= 1'b0;
    end else begin
      s_seg <= seg_n;
      s_an  <= an_n;
      state <= state_n;
      cnt   <= cnt_n;
      chg_q <= chg;
      upd   <= chg_q;
      if (commit && dec_hex) begin
        value[4*int'(idx) +: 4] <= dec_nib;
        blank[idx]              <= 1'b0;
      end
      if (commit && dec_blank)
        blank[idx] <= 1'b1;
      if (commit && !dec_hex && !dec_blank)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: a run-length model of the display reader checked every cycle,
// plus hand-computed expectations after each directed scenario.
module tb_seg7_scan_reader;
  localparam int NDIG   = 4;
  localparam int STABLE = 4;

  logic                clk = 1'b0;
  logic                rst, err_clr, upd, err;
  logic [6:0]          seg_n;
  logic [NDIG-1:0]     an_n, blank;
  logic [4*NDIG-1:0]   value;

  seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n), .err_clr(err_clr),
    .value(value), .blank(blank), .upd(upd), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0, upd_cnt = 0, first_upd = -1, run = 0, c0 = 0;
  bit armed = 0;

  logic [6:0] enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] t2pat [4] = '{7'h40, 7'h24, 7'h30, 7'h19};

  logic [3:0]      m_nib [NDIG];
  logic [NDIG-1:0] m_blank, p_an;
  logic [6:0]      p_seg;
  logic            m_err, m_upd, m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4*NDIG-1:0] mval();
    logic [4*NDIG-1:0] v;
    v = '0;
    for (int i = 0; i < NDIG; i++) v[4*i +: 4] = m_nib[i];
    return v;
  endfunction

  // Display-level model: a digit is committed when the same single-digit
  // pattern has been presented on exactly STABLE consecutive clock edges.
  task automatic modelStep();
    logic chg, do_commit, illegal;
    int   d, found;
    chg = 1'b0; do_commit = 1'b0; illegal = 1'b0; d = 0; found = -1;
    if (rst) begin
      for (int i = 0; i < NDIG; i++) m_nib[i] = 4'h0;
      m_blank = '1; m_err = 1'b0; m_upd = 1'b0; m_pend = 1'b0;
      run = 0; p_an = '1; p_seg = 7'h7F; armed = 1;
      return;
    end
    if ($countones(~an_n) == 1) begin
      if (run > 0 && an_n == p_an && seg_n == p_seg) begin
        if (run < STABLE) begin
          run++;
          do_commit = (run == STABLE);
        end
      end else begin
        run = 1;
      end
    end else begin
      run = 0;
    end
    p_an = an_n; p_seg = seg_n;
    if (do_commit) begin
      for (int i = 0; i < NDIG; i++) if (!an_n[i]) d = i;
      for (int k = 0; k < 16; k++) if (enc[k] == seg_n) found = k;
      if (found >= 0) begin
        chg = (m_nib[d] != 4'(found)) || m_blank[d];
        m_nib[d] = 4'(found);
        m_blank[d] = 1'b0;
      end else if (seg_n == 7'h7F) begin
        chg = !m_blank[d];
        m_blank[d] = 1'b1;
      end else begin
        illegal = 1'b1;
      end
    end
    if (illegal) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    m_upd  = m_pend;
    m_pend = chg;
  endtask

  task automatic checkOutput();
    chk("value", 32'(value), 32'(mval()));
    chk("blank", 32'(blank), 32'(m_blank));
    chk("upd", 32'(upd), 32'(m_upd));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    cyc++;
    @(negedge clk);
    if (armed) checkOutput();
    if (upd === 1'b1) begin
      upd_cnt++;
      if (first_upd < 0) first_upd = cyc;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NDIG-1:0] an, input logic [6:0] seg,
                               input logic clr, input int n);
    repeat (n) begin
      rst = r; an_n = an; seg_n = seg; err_clr = clr;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; an_n = '1; seg_n = 7'h7F; err_clr = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 4'hF, 7'h7F, 1'b0, 3);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_blank", 32'(blank), 32'hF);
    chk("rst_upd", 32'(upd), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    $display("[TB] single digit 1 on digit 0");
    c0 = cyc; upd_cnt = 0; first_upd = -1;
    applyStimulus(1'b0, 4'b1110, 7'h79, 1'b0, 10);
    chk("t1_value", 32'(value), 32'h0001);
    chk("t1_blank", 32'(blank), 32'hE);
    chk("t1_upd_count", 32'(upd_cnt), 32'd1);
    chk("t1_upd_latency", 32'(first_upd - (c0 + 1)), 32'(STABLE));
    chk("t1_err", 32'(err), 32'h0);

    $display("[TB] scan 0,2,3,4 across four digits");
    upd_cnt = 0;
    for (int d = 0; d < 4; d++)
      applyStimulus(1'b0, 4'(~(4'b0001 << d)), t2pat[d], 1'b0, 6);
    applyStimulus(1'b0, 4'hF, 7'h7F, 1'b0, 2);
    chk("t2_value", 32'(value), 32'h4320);
    chk("t2_blank", 32'(blank), 32'h0);
    chk("t2_upd_count", 32'(upd_cnt), 32'd4);

    $display("[TB] run one short of STABLE");
    upd_cnt = 0;
    applyStimulus(1'b0, 4'b1101, 7'h08, 1'b0, STABLE - 1);
    applyStimulus(1'b0, 4'hF, 7'h7F, 1'b0, 4);
    chk("t3_value", 32'(value), 32'h4320);
    chk("t3_upd_count", 32'(upd_cnt), 32'd0);

    $display("[TB] illegal pattern and err_clr priority");
    applyStimulus(1'b0, 4'b1011, 7'h7E, 1'b0, 6);
    chk("t4_err", 32'(err), 32'h1);
    chk("t4_value", 32'(value), 32'h4320);
    chk("t4_blank", 32'(blank), 32'h0);
    applyStimulus(1'b0, 4'hF, 7'h7F, 1'b0, 1);
    applyStimulus(1'b0, 4'b1011, 7'h7E, 1'b0, STABLE - 1);
    applyStimulus(1'b0, 4'b1011, 7'h7E, 1'b1, 1);
    chk("t4_err_set_wins", 32'(err), 32'h1);
    applyStimulus(1'b0, 4'hF, 7'h7F, 1'b1, 1);
    chk("t4_err_cleared", 32'(err), 32'h0);

    $display("[TB] two digits selected");
    upd_cnt = 0;
    applyStimulus(1'b0, 4'b1100, 7'h24, 1'b0, 20);
    chk("t5_upd_count", 32'(upd_cnt), 32'd0);
    chk("t5_value", 32'(value), 32'h4320);

    $display("[TB] reset in the middle of a run");
    applyStimulus(1'b0, 4'hF, 7'h7F, 1'b0, 1);
    upd_cnt = 0;
    applyStimulus(1'b0, 4'b1110, 7'h06, 1'b0, 6);
    chk("t6_value_e", 32'(value), 32'h432E);
    chk("t6_upd_count", 32'(upd_cnt), 32'd1);
    applyStimulus(1'b0, 4'b1110, 7'h0E, 1'b0, 2);
    applyStimulus(1'b1, 4'b1110, 7'h0E, 1'b0, 1);
    chk("t6_rst_value", 32'(value), 32'h0);
    chk("t6_rst_blank", 32'(blank), 32'hF);
    upd_cnt = 0;
    applyStimulus(1'b0, 4'b1110, 7'h06, 1'b0, 6);
    chk("t6_recommit_value", 32'(value), 32'h000E);
    chk("t6_recommit_blank", 32'(blank), 32'hE);
    chk("t6_recommit_upd", 32'(upd_cnt), 32'd1);

    $display("[TB] blank commit and identical recommit");
    applyStimulus(1'b0, 4'hF, 7'h7F, 1'b0, 1);
    upd_cnt = 0;
    applyStimulus(1'b0, 4'b1110, 7'h7F, 1'b0, 6);
    chk("t7_blank", 32'(blank), 32'hF);
    chk("t7_value", 32'(value), 32'h000E);
    chk("t7_upd_count", 32'(upd_cnt), 32'd1);
    applyStimulus(1'b0, 4'hF, 7'h7F, 1'b0, 1);
    upd_cnt = 0;
    applyStimulus(1'b0, 4'b1110, 7'h7F, 1'b0, 6);
    chk("t7_same_upd_count", 32'(upd_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
